// File: rtl/shifter_pkg.sv
// Shared types for the two-stage barrel shifter: operation codes and the
// shift-amount class that stage 1 decodes ahead of the shift itself.
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_LSL = 3'b000,
    OP_LSR = 3'b001,
    OP_ROR = 3'b010,
    OP_ASR = 3'b011,
    OP_RRX = 3'b100
  } shift_op_t;

  typedef enum logic [1:0] {
    AMT_ZERO = 2'd0,
    AMT_LT   = 2'd1,
    AMT_EQ   = 2'd2,
    AMT_GT   = 2'd3
  } amt_class_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shift/rotate datapath. Takes the pre-classified amount and
// r = amt mod WIDTH; for the AMT_LT class r equals the full amount.
module shift_core
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int R_W   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       op,
  input  amt_class_t       amt_cls,
  input  logic [R_W-1:0]   r,
  input  logic             cin,
  output logic [WIDTH-1:0] data,
  output logic             carry
);

  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH:0]   asr_ext;
  logic [WIDTH-1:0] ror_val;

  always_comb begin
    // One extra bit on each side catches the last bit shifted out as carry.
    lsl_ext = {1'b0, a} << r;
    lsr_ext = {a, 1'b0} >> r;
    asr_ext = $signed({a, 1'b0}) >>> r;
    ror_val = (a >> r) | (a << (WIDTH - int'(r)));

    data  = a;
    carry = cin;

    case (op)
      OP_LSL: begin
        case (amt_cls)
          AMT_ZERO: ;
          AMT_LT: begin
            data  = lsl_ext[WIDTH-1:0];
            carry = lsl_ext[WIDTH];
          end
          AMT_EQ: begin
            data  = '0;
            carry = a[0];
          end
          AMT_GT: begin
            data  = '0;
            carry = 1'b0;
          end
        endcase
      end
      OP_LSR: begin
        case (amt_cls)
          AMT_ZERO: ;
          AMT_LT: begin
            data  = lsr_ext[WIDTH:1];
            carry = lsr_ext[0];
          end
          AMT_EQ: begin
            data  = '0;
            carry = a[WIDTH-1];
          end
          AMT_GT: begin
            data  = '0;
            carry = 1'b0;
          end
        endcase
      end
      OP_ASR: begin
        case (amt_cls)
          AMT_ZERO: ;
          AMT_LT: begin
            data  = asr_ext[WIDTH:1];
            carry = asr_ext[0];
          end
          AMT_EQ, AMT_GT: begin
            data  = {WIDTH{a[WIDTH-1]}};
            carry = a[WIDTH-1];
          end
        endcase
      end
      OP_ROR: begin
        if (amt_cls != AMT_ZERO) begin
          if (r == '0) begin
            carry = a[WIDTH-1];
          end else begin
            data  = ror_val;
            carry = ror_val[WIDTH-1];
          end
        end
      end
      OP_RRX: begin
        data  = {cin, a[WIDTH-1:1]};
        carry = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shifter_pipe.sv
// Two-stage valid/ready barrel shifter: stage 1 registers operands plus the
// decoded amount class, stage 2 registers the shift_core result and carry.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int               R_W   = $clog2(WIDTH);
  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [2:0]       s1_op_q, s1_op_d;
  amt_class_t       s1_cls_q, s1_cls_d;
  logic [R_W-1:0]   s1_r_q, s1_r_d;
  logic             s1_cin_q, s1_cin_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_carry_q, out_carry_d;

  amt_class_t       in_cls;
  logic             s2_adv;
  logic             s1_adv;
  logic [WIDTH-1:0] core_data;
  logic             core_carry;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .a       (s1_a_q),
    .op      (s1_op_q),
    .amt_cls (s1_cls_q),
    .r       (s1_r_q),
    .cin     (s1_cin_q),
    .data    (core_data),
    .carry   (core_carry)
  );

  always_comb begin
    if (in_amt == '0)         in_cls = AMT_ZERO;
    else if (in_amt < W_AMT)  in_cls = AMT_LT;
    else if (in_amt == W_AMT) in_cls = AMT_EQ;
    else                      in_cls = AMT_GT;

    // Stage 2 frees up when empty or draining; stage 1 when empty or moving on.
    s2_adv = !out_valid_q || out_ready;
    s1_adv = !reset && (!s1_valid_q || s2_adv);

    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_op_d     = s1_op_q;
    s1_cls_d    = s1_cls_q;
    s1_r_d      = s1_r_q;
    s1_cin_d    = s1_cin_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_carry_d = out_carry_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = in_a;
        s1_op_d  = in_op;
        s1_cls_d = in_cls;
        s1_r_d   = in_amt[R_W-1:0];
        s1_cin_d = in_cin;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d  = core_data;
        out_carry_d = core_carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_op_q     <= '0;
      s1_cls_q    <= AMT_ZERO;
      s1_r_q      <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_op_q     <= s1_op_d;
      s1_cls_q    <= s1_cls_d;
      s1_r_q      <= s1_r_d;
      s1_cin_q    <= s1_cin_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_carry_q <= out_carry_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe (WIDTH=32): hand-computed vectors, latency,
// back-to-back throughput, backpressure and mid-flight reset.
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [2:0]  in_op;
  logic [7:0]  in_amt;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] exp_d;
    logic        exp_c;
  } vec_t;

  shifter_pipe #(.WIDTH(32), .AMT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  // Drives one beat at a negedge and waits (bounded) for its result; lat is
  // the number of cycles after acceptance, -1 on timeout.
  task automatic issue_beat(input logic [31:0] a, input logic [2:0] op,
                            input logic [7:0] amt, input logic cin,
                            output logic rdy, output int lat,
                            output logic [31:0] d, output logic c);
    lat = -1;
    d   = '0;
    c   = 1'b0;
    @(negedge clk);
    in_a = a; in_op = op; in_amt = amt; in_cin = cin; in_valid = 1'b1;
    rdy = in_ready;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        d   = out_data;
        c   = out_carry;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_op = '0; in_amt = '0; in_cin = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    vectors++;
    if (out_carry !== 1'b0) begin miscompares++; $display("FAIL reset_out_carry: got %b expected 0", out_carry); end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_lsl_latency();
    logic rdy; int lat; logic [31:0] d; logic c;
    issue_beat(32'h8000_0001, 3'b000, 8'd1, 1'b0, rdy, lat, d, c);
    vectors++;
    if (rdy !== 1'b1) begin miscompares++; $display("FAIL lsl1_ready: got %b expected 1", rdy); end
    vectors++;
    if (lat != 2) begin miscompares++; $display("FAIL lsl1_latency: got %0d expected 2", lat); end
    vectors++;
    if (d !== 32'h0000_0002) begin miscompares++; $display("FAIL lsl1_data: got %h expected 00000002", d); end
    vectors++;
    if (c !== 1'b1) begin miscompares++; $display("FAIL lsl1_carry: got %b expected 1", c); end
  endtask

  task automatic test_ops();
    vec_t tbl[20];
    logic rdy; int lat; logic [31:0] d; logic c;
    tbl = '{
      '{"lsr_amt32",   3'b001, 32'h8000_0000, 8'd32, 1'b0, 32'h0000_0000, 1'b1},
      '{"asr_amt40",   3'b011, 32'h8000_0000, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1},
      '{"lsl_amt33",   3'b000, 32'h8000_0000, 8'd33, 1'b0, 32'h0000_0000, 1'b0},
      '{"lsl_amt0",    3'b000, 32'h8000_0000, 8'd0,  1'b1, 32'h8000_0000, 1'b1},
      '{"lsr_amt0",    3'b001, 32'h8000_0000, 8'd0,  1'b1, 32'h8000_0000, 1'b1},
      '{"ror_amt0",    3'b010, 32'h8000_0000, 8'd0,  1'b1, 32'h8000_0000, 1'b1},
      '{"asr_amt0",    3'b011, 32'h8000_0000, 8'd0,  1'b1, 32'h8000_0000, 1'b1},
      '{"lsl_amt32",   3'b000, 32'h8000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1},
      '{"lsl_amt31",   3'b000, 32'h0000_0002, 8'd31, 1'b0, 32'h0000_0000, 1'b1},
      '{"lsr_amt1",    3'b001, 32'h0000_0003, 8'd1,  1'b0, 32'h0000_0001, 1'b1},
      '{"lsr_amt31",   3'b001, 32'h8000_0000, 8'd31, 1'b0, 32'h0000_0001, 1'b0},
      '{"asr_amt5",    3'b011, 32'h8000_0010, 8'd5,  1'b0, 32'hFC00_0000, 1'b1},
      '{"asr_pos32",   3'b011, 32'h4000_0000, 8'd32, 1'b0, 32'h0000_0000, 1'b0},
      '{"ror_amt36",   3'b010, 32'h0000_00F1, 8'd36, 1'b0, 32'h1000_000F, 1'b0},
      '{"ror_amt32",   3'b010, 32'h8000_0000, 8'd32, 1'b0, 32'h8000_0000, 1'b1},
      '{"ror_amt8",    3'b010, 32'h1234_5678, 8'd8,  1'b0, 32'h7812_3456, 1'b0},
      '{"rrx_cin1",    3'b100, 32'h0000_0003, 8'd5,  1'b1, 32'h8000_0001, 1'b1},
      '{"rrx_cin0",    3'b100, 32'h8000_0000, 8'd0,  1'b0, 32'h4000_0000, 1'b0},
      '{"pass_op5",    3'b101, 32'h1234_5678, 8'd5,  1'b1, 32'h1234_5678, 1'b1},
      '{"pass_op7",    3'b111, 32'hCAFE_F00D, 8'd9,  1'b0, 32'hCAFE_F00D, 1'b0}
    };
    for (int k = 0; k < 20; k++) begin
      issue_beat(tbl[k].a, tbl[k].op, tbl[k].amt, tbl[k].cin, rdy, lat, d, c);
      vectors++;
      if (lat != 2) begin miscompares++; $display("FAIL %s_latency: got %0d expected 2", tbl[k].name, lat); end
      vectors++;
      if (d !== tbl[k].exp_d) begin miscompares++; $display("FAIL %s_data: got %h expected %h", tbl[k].name, d, tbl[k].exp_d); end
      vectors++;
      if (c !== tbl[k].exp_c) begin miscompares++; $display("FAIL %s_carry: got %b expected %b", tbl[k].name, c, tbl[k].exp_c); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[4]  = '{3'b000, 3'b001, 3'b010, 3'b100};
    logic [31:0] as[4]   = '{32'h1, 32'h100, 32'h3, 32'h2};
    logic [7:0]  amts[4] = '{8'd4, 8'd8, 8'd1, 8'd0};
    logic [31:0] exd[4]  = '{32'h10, 32'h1, 32'h8000_0001, 32'h1};
    logic        exc[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        in_a = as[i]; in_op = ops[i]; in_amt = amts[i]; in_cin = 1'b0; in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2 && i < 6) begin
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
        vectors++;
        if (out_data !== exd[i-2] || out_carry !== exc[i-2])
          begin miscompares++; $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", i-2, out_data, out_carry, exd[i-2], exc[i-2]); end
      end else if (i == 6) begin
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  ops[3]  = '{3'b001, 3'b100, 3'b010};
    logic [31:0] as[3]   = '{32'hF0, 32'h1, 32'h1};
    logic [7:0]  amts[3] = '{8'd4, 8'd0, 8'd1};
    logic [31:0] exd[3]  = '{32'hF, 32'h0, 32'h8000_0000};
    logic        exc[3]  = '{1'b0, 1'b1, 1'b1};
    logic [31:0] got_d[8];
    logic        got_c[8];
    int n;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = as[i]; in_op = ops[i]; in_amt = amts[i]; in_cin = 1'b0; in_valid = 1'b1;
      vectors++;
      if (in_ready !== (i < 2)) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b expected %b", i, in_ready, (i < 2)); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", i, in_ready); end
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'hF || out_carry !== 1'b0)
        begin miscompares++; $display("FAIL bp_stall_hold[%0d]: got %b/%h/%b expected 1/0000000f/0", i, out_valid, out_data, out_carry); end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    n = 0;
    if (out_valid) begin got_d[n] = out_data; got_c[n] = out_carry; n++; end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        if (n < 8) begin got_d[n] = out_data; got_c[n] = out_carry; end
        n++;
      end
    end
    vectors++;
    if (n != 3) begin miscompares++; $display("FAIL bp_count: got %0d expected 3", n); end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (k >= n || got_d[k] !== exd[k] || got_c[k] !== exc[k])
        begin miscompares++; $display("FAIL bp_order[%0d]: got %h/%b expected %h/%b", k, got_d[k], got_c[k], exd[k], exc[k]); end
    end
  endtask

  task automatic test_reset_midflight();
    logic rdy; int lat; logic [31:0] d; logic c;
    out_ready = 1'b0;
    @(negedge clk);
    in_a = 32'h1; in_op = 3'b000; in_amt = 8'd1; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_amt = 8'd2;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin miscompares++; $display("FAIL rst_full: got valid=%b ready=%b expected 1/0", out_valid, in_ready); end
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_during: got %b expected 0", in_ready); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_carry !== 1'b0)
      begin miscompares++; $display("FAIL rst_cleared: got %b/%h/%b expected 0/00000000/0", out_valid, out_data, out_carry); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_held: got %b expected 0", in_ready); end
    reset = 1'b0;
    in_valid = 1'b0;
    issue_beat(32'hF0, 3'b001, 8'd4, 1'b0, rdy, lat, d, c);
    vectors++;
    if (rdy !== 1'b1) begin miscompares++; $display("FAIL rst_new_ready: got %b expected 1", rdy); end
    vectors++;
    if (lat != 2) begin miscompares++; $display("FAIL rst_new_latency: got %0d expected 2", lat); end
    vectors++;
    if (d !== 32'h0000_000F || c !== 1'b0)
      begin miscompares++; $display("FAIL rst_new_result: got %h/%b expected 0000000f/0", d, c); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_stale: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_lsl_latency();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
